// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the EXU and a handshaked memory port.
// Builds byte strobes and lane-shifted store data from size/offset, extracts
// and extends load data, and sequences each access through a
// request / wait / response FSM guarded by a timeout watchdog. Misaligned
// or illegally sized accesses are trapped without any memory traffic.
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic                accept;
    logic [OFF_W-1:0]    req_off;

    // Access is legal when the size fits the bus and the offset is a
    // multiple of the access width.
    function automatic logic access_ok(input logic [OFF_W-1:0] off,
                                       input logic [1:0]       size);
        logic [OFF_W-1:0] ones;
        ones = '1;
        if ((DATA_W < 64) && (size == 2'b11)) begin
            return 1'b0;
        end
        return (off & ~(ones << size)) == '0;
    endfunction

    // One strobe bit per byte of the access, moved up to the byte offset.
    function automatic logic [STRB_W-1:0] strobe_gen(input logic [OFF_W-1:0] off,
                                                     input logic [1:0]       size);
        logic [STRB_W-1:0] ones;
        ones = '1;
        return ~(ones << (1 << size)) << off;
    endfunction

    // Store data is LSB-justified on the request side; move it to its lanes.
    function automatic logic [DATA_W-1:0] lane_shift(input logic [DATA_W-1:0] data,
                                                     input logic [OFF_W-1:0]  off);
        return data << {off, 3'b000};
    endfunction

    // Bring the addressed bytes down to bit 0, keep 8<<size bits and extend.
    // Extension is done by parking the field at the top of the word and
    // shifting back down, arithmetically for signed loads.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic [1:0]        size,
                                                      input logic              sgn);
        logic        [DATA_W-1:0] lane;
        logic signed [DATA_W-1:0] top;
        int                       pad;
        lane = raw >> {off, 3'b000};
        pad  = DATA_W - (8 << size);
        if (pad < 0) begin
            pad = 0;
        end
        top = $signed(lane << pad);
        if (sgn) begin
            return $unsigned(top >>> pad);
        end
        return (lane << pad) >> pad;
    endfunction

    assign accept  = req_valid & req_ready;
    assign req_off = req_addr[OFF_W-1:0];

    // Next-state and datapath capture for the access sequencer.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    off_d   = req_off;
                    addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d = lane_shift(req_wdata, req_off);
                    wstrb_d = strobe_gen(req_off, req_size);
                    rdata_d = '0;
                    timer_d = '0;
                    if (access_ok(req_off, req_size)) begin
                        err_d   = ERR_OK;
                        state_d = ST_REQ;
                    end else begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A response in the last allowed cycle still beats the watchdog.
                if (mem_rsp_valid) begin
                    err_d   = ERR_OK;
                    rdata_d = we_q ? '0 : load_extend(mem_rdata, off_q, size_q, sgn_q);
                    state_d = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-access registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

endmodule
